pcie_wr_hdr_ctrl: RTL and testbench
===================================

# pcie_wr_hdr_ctrl

Write-request front end of the PCIe block. It captures a 96-bit TLP header written over APB and a single-beat write address from AXI AW. When both are present, it presents the decoded TLP header fields and address to the TLP builder, then closes the AXI write with a B response carrying the AW ID. W-channel data is handled by a separate datapath and is out of scope.

## Interface
- ID_WIDTH, 4: AXI ID width.
- ADDR_WIDTH, 32: AXI address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  12  APB byte address; only bits [3:2] are decoded.
- pwdata  in  32  APB write data.
- pready  out  1  APB ready; always 1 (zero wait states).
- prdata  out  32  APB read data.
- pslverr  out  1  APB error.
- awvalid  in  1  AW valid.
- awready  out  1  AW ready.
- awid  in  ID_WIDTH  AW ID.
- awaddr  in  ADDR_WIDTH  AW address.
- awlen  in  8  AW burst length minus one.
- awsize  in  3  AW size.
- awburst  in  2  AW burst type.
- bvalid  out  1  B valid.
- bready  in  1  B ready.
- bid  out  ID_WIDTH  B ID.
- bresp  out  2  B response.
- tlp_valid_o  out  1  TLP fields valid.
- tlp_ready_i  in  1  TLP builder accepts.
- header_fmt_o  out  3  TLP format.
- header_type_o  out  5  TLP type.
- header_tc_o  out  3  traffic class.
- header_length_o  out  9  length.
- header_requestID_o  out  16  requester ID.
- header_completID_o  out  16  completer ID.
- addr_out  out  32  request address.

## Operation
- Header registers: HDR0 at 0x0, HDR1 at 0x4, HDR2 at 0x8.
  - An APB write (psel & penable & pwrite) stores pwdata.
  - A write to HDR2 sets hdr_valid.
  - A write to 0xC gives pslverr=1 and is ignored.
  - While hdr_valid=1, any header write gives pslverr=1 and is ignored.
- Field decode:
  - fmt = HDR0[31:29], type = HDR0[28:24], tc = HDR0[22:20], length = HDR0[8:0].
  - requestID = HDR1[31:16].
  - completID = HDR2[31:16].
- AW acceptance:
  - awready=1 only in IDLE with no AW captured.
  - On handshake, latch awid and awaddr, and set aw_err.
  - aw_err=1 if awlen≠0, awburst≠INCR (2'b01), or awsize≠3'b100 (16 B).
- FSM states IDLE, EMIT, RESP:
  - IDLE → EMIT when AW is captured, hdr_valid=1 and aw_err=0.
  - IDLE → RESP directly when AW is captured and aw_err=1. hdr_valid is kept for the next request.
  - EMIT: tlp_valid_o=1 and fields are stable. On tlp_ready_i, clear hdr_valid and go to RESP.
  - RESP: bvalid=1, bid = latched awid, bresp = 2'b00 (OKAY) or 2'b10 (SLVERR if aw_err). On bready, clear the AW capture and return to IDLE.
- AW and the header may arrive in either order or in the same cycle.

## Timing
- Reset values: awready=0 during rst, then 1. bvalid=0, bid=0, bresp=0, tlp_valid_o=0, all header/addr outputs 0, prdata=0, pslverr=0, hdr_valid=0, state IDLE.
- APB: no wait states. pslverr is valid in the access phase.
- The last of (AW handshake, HDR2 write) in cycle N gives tlp_valid_o=1 at N+1.
- tlp handshake at cycle M gives bvalid=1 at M+1.
- B handshake at cycle K gives awready=1 at K+1.
- bvalid and bid/bresp hold until bready. tlp_valid_o and fields hold until tlp_ready_i.
- Reset mid-transaction aborts everything; no B is issued for the aborted AW.

## Configuration
- PCIE_HDR_READBACK_EN:
  - Defined: APB reads of 0x0/0x4/0x8 return HDR0/1/2, and 0xC returns {31'b0, hdr_valid}.
  - Undefined: prdata is always 0 and every APB read gives pslverr=1.

## Test plan
- HDR = 3×0x01234567, then AW id=0, addr=0x0, len=0, size=16B, INCR → fmt=0, type=0x01, tc=2, length=0x167, requestID=0x0123, completID=0x0123, addr_out=0; then B with bid=0, bresp=00.
- Six back-to-back requests, ids 0..5, addr alternating 0x0/0x20, AW concurrent with the APB header → six TLPs and six B responses, bid in order 0..5, all OKAY.
- AW arrives 10 cycles before HDR2 is written → tlp_valid_o rises exactly 1 cycle after the HDR2 write.
- AW with awlen=1 → no tlp_valid_o; B with bresp=10 and matching bid; the header stays valid for the next AW.
- Hold tlp_ready_i=0 for 5 cycles, then bready=0 for 3 cycles → outputs stable, bvalid held; an APB header write during the hold gives pslverr=1.
- Assert rst while in EMIT → all outputs return to reset values the next cycle; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/pcie_wr_hdr_ctrl.sv
// pcie_wr_hdr_ctrl
//   Write-request front end. A 96-bit TLP header is loaded through APB
//   (HDR0 @0x0, HDR1 @0x4, HDR2 @0x8; writing HDR2 marks the header valid).
//   A single-beat AXI AW request is captured alongside it. When both are
//   present the decoded header fields and the address go to the TLP builder.
//   The AXI write is then closed with a B response that carries the AW ID.
//   W data is handled elsewhere.
//
// Optional feature (macro PCIE_HDR_READBACK_EN):
//   defined   - APB reads return HDR0/1/2, and 0xC returns {31'b0, hdr_valid}
//   undefined - APB reads return 0 with pslverr=1
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   psel/penable/pwrite      APB control
//   paddr[11:0], pwdata      APB address (bits [3:2] decoded) / write data
//   pready, prdata, pslverr  APB response (zero wait states)
//   aw*                      AXI write-address channel (awready out)
//   bvalid/bready/bid/bresp  AXI write-response channel
//   tlp_valid_o/tlp_ready_i  handshake to the TLP builder
//   header_*_o, addr_out     decoded TLP header fields and request address
module pcie_wr_hdr_ctrl #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // APB
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [11:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  // AXI AW
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  // AXI B
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  // TLP builder
  output logic                  tlp_valid_o,
  input  logic                  tlp_ready_i,
  output logic [2:0]            header_fmt_o,
  output logic [4:0]            header_type_o,
  output logic [2:0]            header_tc_o,
  output logic [8:0]            header_length_o,
  output logic [15:0]           header_requestID_o,
  output logic [15:0]           header_completID_o,
  output logic [31:0]           addr_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  state_t                state_q, state_d;
  logic [31:0]           hdr0_q, hdr0_d;
  logic [31:0]           hdr1_q, hdr1_d;
  logic [31:0]           hdr2_q, hdr2_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  aw_err_q, aw_err_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;

  logic       apb_acc;
  logic       apb_wr;
  logic [1:0] apb_idx;
  logic       hdr_wr_ok;
  logic       aw_hs;
  logic       aw_bad;

  assign apb_acc   = psel & penable;
  assign apb_wr    = apb_acc & pwrite;
  assign apb_idx   = paddr[3:2];
  // Header registers are locked while a header is pending; 0xC is not writable.
  assign hdr_wr_ok = apb_wr & (apb_idx != 2'd3) & ~hdr_valid_q;
  assign aw_hs     = awvalid & awready;
  assign aw_bad    = (awlen != 8'd0) | (awburst != BURST_INCR) | (awsize != SIZE_16B);

  // Header registers, AW capture and next state
  always_comb begin
    state_d     = state_q;
    hdr0_d      = hdr0_q;
    hdr1_d      = hdr1_q;
    hdr2_d      = hdr2_q;
    hdr_valid_d = hdr_valid_q;
    aw_cap_d    = aw_cap_q;
    aw_err_d    = aw_err_q;
    awid_d      = awid_q;
    awaddr_d    = awaddr_q;

    if (hdr_wr_ok) begin
      unique case (apb_idx)
        2'd0: hdr0_d = pwdata;
        2'd1: hdr1_d = pwdata;
        2'd2: begin
          hdr2_d      = pwdata;
          hdr_valid_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (aw_hs) begin
      aw_cap_d = 1'b1;
      aw_err_d = aw_bad;
      awid_d   = awid;
      awaddr_d = awaddr;
    end

    unique case (state_q)
      // The next-cycle capture/valid values are used here so that the later of
      // the AW handshake and the HDR2 write leads to EMIT on the following cycle.
      S_IDLE: begin
        if (aw_cap_d) begin
          if (aw_err_d) begin
            state_d = S_RESP;
          end else if (hdr_valid_d) begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (tlp_ready_i) begin
          hdr_valid_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bready) begin
          aw_cap_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr0_q      <= '0;
      hdr1_q      <= '0;
      hdr2_q      <= '0;
      hdr_valid_q <= 1'b0;
      aw_cap_q    <= 1'b0;
      aw_err_q    <= 1'b0;
      awid_q      <= '0;
      awaddr_q    <= '0;
    end else begin
      state_q     <= state_d;
      hdr0_q      <= hdr0_d;
      hdr1_q      <= hdr1_d;
      hdr2_q      <= hdr2_d;
      hdr_valid_q <= hdr_valid_d;
      aw_cap_q    <= aw_cap_d;
      aw_err_q    <= aw_err_d;
      awid_q      <= awid_d;
      awaddr_q    <= awaddr_d;
    end
  end

  // Channel outputs
  always_comb begin
    awready     = ~rst & (state_q == S_IDLE) & ~aw_cap_q;
    tlp_valid_o = (state_q == S_EMIT);
    bvalid      = (state_q == S_RESP);
    bid         = bvalid ? awid_q : '0;
    bresp       = (bvalid & aw_err_q) ? RESP_SLV : RESP_OKAY;
  end

  // Decoded header fields
  assign header_fmt_o       = hdr0_q[31:29];
  assign header_type_o      = hdr0_q[28:24];
  assign header_tc_o        = hdr0_q[22:20];
  assign header_length_o    = hdr0_q[8:0];
  assign header_requestID_o = hdr1_q[31:16];
  assign header_completID_o = hdr2_q[31:16];

  if (ADDR_WIDTH >= 32) begin : g_addr_trunc
    assign addr_out = awaddr_q[31:0];
  end else begin : g_addr_ext
    assign addr_out = {{(32-ADDR_WIDTH){1'b0}}, awaddr_q};
  end

  // APB response
  assign pready = 1'b1;

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (apb_acc && !rst) begin
      if (pwrite) begin
        pslverr = (apb_idx == 2'd3) | hdr_valid_q;
      end else begin
`ifdef PCIE_HDR_READBACK_EN
        unique case (apb_idx)
          2'd0:    prdata = hdr0_q;
          2'd1:    prdata = hdr1_q;
          2'd2:    prdata = hdr2_q;
          default: prdata = {31'b0, hdr_valid_q};
        endcase
`else
        pslverr = 1'b1;
`endif
      end
    end
  end

  // Header bits that carry no decoded field, and undecoded address bits
  logic unused_bits;
  assign unused_bits = ^{paddr[11:4], paddr[1:0], hdr0_q[23], hdr0_q[19:9],
                         hdr1_q[15:0], hdr2_q[15:0]};

  a_one_hot_out: assert property (@(posedge clk) disable iff (rst)
                                  !(tlp_valid_o && bvalid));
  a_awready_idle: assert property (@(posedge clk) disable iff (rst)
                                   awready |-> !(tlp_valid_o || bvalid));

endmodule

// File: tb/tb_pcie_wr_hdr_ctrl.sv
module tb_pcie_wr_hdr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        tlp_valid_o, tlp_ready_i;
  logic [2:0]  header_fmt_o;
  logic [4:0]  header_type_o;
  logic [2:0]  header_tc_o;
  logic [8:0]  header_length_o;
  logic [15:0] header_requestID_o, header_completID_o;
  logic [31:0] addr_out;

  // ready sources: manual (directed tests) or random (random phase)
  logic rand_rdy = 1'b0;
  logic tlp_rdy_man, tlp_rdy_rnd, b_rdy_man, b_rdy_rnd;
  assign tlp_ready_i = rand_rdy ? tlp_rdy_rnd : tlp_rdy_man;
  assign bready      = rand_rdy ? b_rdy_rnd : b_rdy_man;

  pcie_wr_hdr_ctrl #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .tlp_valid_o(tlp_valid_o), .tlp_ready_i(tlp_ready_i),
    .header_fmt_o(header_fmt_o), .header_type_o(header_type_o),
    .header_tc_o(header_tc_o), .header_length_o(header_length_o),
    .header_requestID_o(header_requestID_o), .header_completID_o(header_completID_o),
    .addr_out(addr_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Request-level view: a stored header (+ valid flag), at most one pending
  // AW request, and which of the two outgoing handshakes is being offered.
  logic [31:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;
  logic        m_hv = 1'b0, m_held = 1'b0, m_err = 1'b0;
  logic        m_tlp = 1'b0, m_b = 1'b0;
  logic [3:0]  m_id = '0;
  logic [31:0] m_addr = '0;
  logic [5:0]  exp_b_q[$];   // {bresp, bid} in AW acceptance order

  always @(posedge clk) begin : model_p
    logic hv, held, err, tlp, b, wr_ok;
    logic [1:0] idx;
    if (rst) begin
      m_h0 <= '0; m_h1 <= '0; m_h2 <= '0;
      m_hv <= 1'b0; m_held <= 1'b0; m_err <= 1'b0;
      m_tlp <= 1'b0; m_b <= 1'b0; m_id <= '0; m_addr <= '0;
      exp_b_q.delete();
    end else begin
      hv = m_hv; held = m_held; err = m_err; tlp = m_tlp; b = m_b;
      idx   = paddr[3:2];
      wr_ok = psel && penable && pwrite && (idx != 2'd3) && !m_hv;
      if (wr_ok) begin
        case (idx)
          2'd0: m_h0 <= pwdata;
          2'd1: m_h1 <= pwdata;
          default: begin m_h2 <= pwdata; hv = 1'b1; end
        endcase
      end
      if (awvalid && !m_held && !m_tlp && !m_b) begin
        held = 1'b1;
        err  = (awlen != 8'd0) || (awburst != 2'b01) || (awsize != 3'b100);
        m_id   <= awid;
        m_addr <= awaddr;
        exp_b_q.push_back({err ? 2'b10 : 2'b00, awid});
      end
      if (m_tlp && tlp_ready_i) begin tlp = 1'b0; hv = 1'b0; b = 1'b1; end
      if (m_b && bready)        begin b = 1'b0; held = 1'b0; end
      if (!m_tlp && !m_b && held) begin
        if (err)     b   = 1'b1;
        else if (hv) tlp = 1'b1;
      end
      m_hv <= hv; m_held <= held; m_err <= err; m_tlp <= tlp; m_b <= b;
    end
  end

  // ---------------- compare process ----------------
  int          b_done = 0, tlp_done = 0;
  logic [5:0]  b_log[$];
  logic [2:0]  last_fmt; logic [4:0] last_type; logic [2:0] last_tc;
  logic [8:0]  last_len; logic [15:0] last_rid, last_cid; logic [31:0] last_addr;
  logic [3:0]  last_bid; logic [1:0] last_bresp;

  always @(negedge clk) begin : cmp_p
    logic [5:0]  e;
    logic        exp_err;
    logic [31:0] exp_rd;
    check("pready", pready, 1'b1);
    check("awready", awready, !rst && !m_held && !m_tlp && !m_b);
    check("tlp_valid", tlp_valid_o, m_tlp);
    check("bvalid", bvalid, m_b);
    if (m_tlp) begin
      check("fmt", header_fmt_o, m_h0[31:29]);
      check("type", header_type_o, m_h0[28:24]);
      check("tc", header_tc_o, m_h0[22:20]);
      check("length", header_length_o, m_h0[8:0]);
      check("reqid", header_requestID_o, m_h1[31:16]);
      check("cplid", header_completID_o, m_h2[31:16]);
      check("addr_out", addr_out, m_addr);
    end
    if (m_b) begin
      check("bid", bid, m_id);
      check("bresp", bresp, m_err ? 2'b10 : 2'b00);
    end
    if (psel && penable) begin
      exp_rd = '0;
      if (pwrite) exp_err = !rst && (paddr[3:2] == 2'd3 || m_hv);
      else begin
`ifdef PCIE_HDR_READBACK_EN
        exp_err = 1'b0;
        if (!rst) begin
          case (paddr[3:2])
            2'd0: exp_rd = m_h0;
            2'd1: exp_rd = m_h1;
            2'd2: exp_rd = m_h2;
            default: exp_rd = {31'b0, m_hv};
          endcase
        end
`else
        exp_err = !rst;
`endif
        check("prdata", prdata, exp_rd);
      end
      check("pslverr", pslverr, exp_err);
    end
    if (!rst && tlp_valid_o && tlp_ready_i) begin
      tlp_done  <= tlp_done + 1;
      last_fmt  <= header_fmt_o;   last_type <= header_type_o;
      last_tc   <= header_tc_o;    last_len  <= header_length_o;
      last_rid  <= header_requestID_o; last_cid <= header_completID_o;
      last_addr <= addr_out;
    end
    if (!rst && bvalid && bready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", 1'b1, 1'b0);
      else begin
        e = exp_b_q.pop_front();
        check("b_order", {bresp, bid}, e);
      end
      b_log.push_back({bresp, bid});
      last_bid   <= bid;
      last_bresp <= bresp;
      b_done     <= b_done + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    tlp_rdy_rnd = ($urandom_range(0, 2) != 0);
    b_rdy_rnd   = ($urandom_range(0, 2) != 0);
  end

  // ---------------- stimulus tasks (called at posedge+1) ----------------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                           output logic err, output logic tv);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); err = pslverr; tv = tlp_valid_o;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); err = pslverr; d = prdata;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
  endtask

  task automatic hdr_write3(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    logic e, t;
    apb_write(12'h000, d0, e, t);
    apb_write(12'h004, d1, e, t);
    apb_write(12'h008, d2, e, t);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    logic done = 1'b0;
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu;
    while (!done && n < 300) begin
      @(negedge clk);
      if (awready) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    awvalid = 1'b0;
    if (!done) check("aw_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_done < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (b_done < target) check("b_timeout", b_done, target);
  endtask

  task automatic wait_tlp();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (tlp_valid_o) seen = 1'b1;
      n++;
    end
    if (!seen) check("tlp_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic        e, tv;
    logic [31:0] rd;
    int          base, t0, b0;
    logic [2:0]  c_fmt; logic [8:0] c_len; logic [15:0] c_rid; logic [31:0] c_addr;

    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    tlp_rdy_man = 1'b1; b_rdy_man = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_outs", {tlp_valid_o, bvalid, bid, bresp, pslverr}, '0);
    check("rst_fields", {header_fmt_o, header_type_o, header_tc_o, header_length_o,
                         header_requestID_o, header_completID_o}, '0);
    check("rst_addr", addr_out, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("awready_after_rst", awready, 1'b1);
    @(posedge clk); #1;

    // 1: basic request with fixed header
    hdr_write3(32'h01234567, 32'h01234567, 32'h01234567);
    aw_send(4'd0, 32'h0, 8'd0, 3'b100, 2'b01);
    wait_b(1);
    check("t1_fmt", last_fmt, 3'd0);
    check("t1_type", last_type, 5'h01);
    check("t1_tc", last_tc, 3'd2);
    check("t1_len", last_len, 9'h167);
    check("t1_rid", last_rid, 16'h0123);
    check("t1_cid", last_cid, 16'h0123);
    check("t1_addr", last_addr, 32'h0);
    check("t1_b", {last_bresp, last_bid}, 6'h00);

    // 2: six requests, AW concurrent with header
    base = b_log.size(); t0 = tlp_done;
    for (int i = 0; i < 6; i++) begin
      fork
        hdr_write3($urandom, $urandom, $urandom);
        aw_send(4'(i), (i % 2) ? 32'h20 : 32'h0, 8'd0, 3'b100, 2'b01);
      join
      wait_b(base + i + 1);
    end
    for (int i = 0; i < 6; i++) check("t2_b", b_log[base + i], {2'b00, 4'(i)});
    check("t2_tlps", tlp_done - t0, 6);

    // 3: AW ten cycles ahead of HDR2
    aw_send(4'd7, 32'h40, 8'd0, 3'b100, 2'b01);
    apb_write(12'h000, 32'hA5F00123, e, tv);
    apb_write(12'h004, 32'hBEEF0000, e, tv);
    repeat (4) @(posedge clk);
    #1;
    apb_write(12'h008, 32'hCAFE0000, e, tv);
    check("t3_tv_before", tv, 1'b0);
    @(negedge clk);
    check("t3_tv_after", tlp_valid_o, 1'b1);
    @(posedge clk); #1;
    wait_b(b_done + 1);
    check("t3_b", {last_bresp, last_bid}, {2'b00, 4'd7});

    // 4: illegal AW keeps the header for the next one
    hdr_write3(32'h6A300010, 32'h11110000, 32'h22220000);
    t0 = tlp_done;
    aw_send(4'd9, 32'h0, 8'd1, 3'b100, 2'b01);
    wait_b(b_done + 1);
    check("t4_err_b", {last_bresp, last_bid}, {2'b10, 4'd9});
    check("t4_no_tlp", tlp_done, t0);
    apb_write(12'h000, 32'hFFFFFFFF, e, tv);
    check("t4_hdr_locked", e, 1'b1);
    aw_send(4'd10, 32'h60, 8'd0, 3'b100, 2'b01);
    wait_b(b_done + 1);
    check("t4_ok_b", {last_bresp, last_bid}, {2'b00, 4'd10});
    check("t4_tlp", tlp_done, t0 + 1);
    check("t4_len", last_len, 9'h010);
    check("t4_rid", last_rid, 16'h1111);

    // 5: back-pressure on both outputs
    tlp_rdy_man = 1'b0; b_rdy_man = 1'b0;
    hdr_write3(32'h20000ABC, 32'h33330000, 32'h44440000);
    aw_send(4'd3, 32'h80, 8'd0, 3'b100, 2'b01);
    wait_tlp();
    c_fmt = header_fmt_o; c_len = header_length_o; c_rid = header_requestID_o; c_addr = addr_out;
    apb_write(12'h004, 32'h0, e, tv);
    check("t5_pslverr_hold", e, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_tv_hold", tlp_valid_o, 1'b1);
      check("t5_fields_hold", {header_fmt_o, header_length_o, header_requestID_o, addr_out},
            {c_fmt, c_len, c_rid, c_addr});
      @(posedge clk); #1;
    end
    tlp_rdy_man = 1'b1;
    @(posedge clk); #1;
    tlp_rdy_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_b_hold", {bvalid, bresp, bid}, {1'b1, 2'b00, 4'd3});
      @(posedge clk); #1;
    end
    b_rdy_man = 1'b1;
    wait_b(b_done + 1);

    // 6: reset while emitting
    hdr_write3(32'h40000001, 32'h55550000, 32'h66660000);
    aw_send(4'd5, 32'hA0, 8'd0, 3'b100, 2'b01);
    wait_tlp();
    b0 = b_done;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_outs", {awready, tlp_valid_o, bvalid, bid, bresp}, '0);
    check("t6_rst_fields", {header_fmt_o, header_length_o, header_requestID_o,
                            header_completID_o, addr_out}, '0);
    @(posedge clk); #1; rst = 1'b0;
    tlp_rdy_man = 1'b1;
    @(negedge clk);
    check("t6_awready", awready, 1'b1);
    @(posedge clk); #1;
    check("t6_no_b", b_done, b0);
    hdr_write3(32'h00000004, 32'h77770000, 32'h88880000);
    aw_send(4'd12, 32'hC0, 8'd0, 3'b100, 2'b01);
    wait_b(b0 + 1);
    check("t6_fresh_b", {last_bresp, last_bid}, {2'b00, 4'd12});
    check("t6_fresh_addr", last_addr, 32'hC0);

    // 7: randomized traffic with random ready back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] len; logic [2:0] sz; logic [1:0] bu;
      len = 8'd0; sz = 3'b100; bu = 2'b01;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: len = 8'($urandom_range(1, 255));
          1: sz  = 3'($urandom_range(0, 3));
          default: bu = 2'($urandom_range(2, 3));
        endcase
      end
      case ($urandom_range(0, 3))
        0: apb_read(12'($urandom_range(0, 3) * 4), rd, e);
        1: apb_write(12'h00C, $urandom, e, tv);
        default: ;
      endcase
      b0 = b_done;
      fork
        hdr_write3($urandom, $urandom, $urandom);
        begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1;
          aw_send(4'($urandom), $urandom & 32'hFFFF_FFF0, len, sz, bu);
        end
      join
      wait_b(b0 + 1);
    end
    rand_rdy = 1'b0;
    repeat (4) @(posedge clk);
    check("queue_drained", exp_b_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
